// File: rtl/fsm_seq_ctrl_if.sv
// Host and controlled-FSM signal bundle for the stimulus sequencer.
interface fsm_seq_ctrl_if #(
  parameter int unsigned DEPTH = 16
);
  logic             wr_en;
  logic [1:0]       wr_ab;
  logic             clr;
  logic             start;
  logic             fsm_out;
  logic             fsm_rst;
  logic             fsm_a;
  logic             fsm_b;
  logic             busy;
  logic             done;
  logic [4:0]       count;
  logic [DEPTH-1:0] result;
  logic             err;

  // Host / environment side
  modport master (
    output wr_en, wr_ab, clr, start, fsm_out,
    input  fsm_rst, fsm_a, fsm_b, busy, done, count, result, err
  );

  // Sequencer side
  modport slave (
    input  wr_en, wr_ab, clr, start, fsm_out,
    output fsm_rst, fsm_a, fsm_b, busy, done, count, result, err
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Stores up to DEPTH two-bit {A,B} vectors, then replays them into an external FSM after
// resetting it, capturing the FSM's registered output for every vector.
module fsm_seq_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  fsm_seq_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  Full = 5'(DEPTH);

  typedef enum logic [2:0] {StIdle, StDutRst, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mem_q [DEPTH];
  logic [4:0]       count_q;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW-1:0]  cap_idx_q;
  logic             cap_vld_q;
  logic             rst_cnt_q;
  logic             fsm_rst_q;
  logic             fsm_a_q;
  logic             fsm_b_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [DEPTH-1:0] result_q;

  logic [IdxW-1:0]  last_idx;
  logic [IdxW-1:0]  idx_nxt;

  assign last_idx = IdxW'(count_q - 5'd1);
  assign idx_nxt  = idx_q + 1'b1;

  // Sequencer FSM: all outputs registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      idx_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      rst_cnt_q <= 1'b0;
      fsm_rst_q <= 1'b1;  // keep the controlled FSM in reset while we are
      fsm_a_q   <= 1'b0;
      fsm_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // fsm_out reflects the vector driven in the previous cycle, so capture lags by one.
      if (cap_vld_q) result_q[cap_idx_q] <= bus.fsm_out;
      cap_vld_q <= (state_q == StRun);
      cap_idx_q <= idx_q;
      if ((state_q != StIdle) && (bus.wr_en || bus.start)) err_q <= 1'b1;

      case (state_q)
        StIdle: begin
          fsm_rst_q <= 1'b0;
          if (bus.clr) begin
            count_q <= 5'd0;
          end else if (bus.wr_en && bus.start) begin
            err_q <= 1'b1;
          end else if (bus.wr_en) begin
            if (count_q == Full) begin
              err_q <= 1'b1;
            end else begin
              mem_q[count_q[IdxW-1:0]] <= bus.wr_ab;
              count_q                  <= count_q + 5'd1;
            end
          end else if (bus.start) begin
            if (count_q == 5'd0) begin
              err_q <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              result_q  <= '0;
              idx_q     <= '0;
              rst_cnt_q <= 1'b0;
              fsm_rst_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= StDutRst;
            end
          end
        end
        StDutRst: begin
          if (rst_cnt_q) begin
            fsm_rst_q          <= 1'b0;
            idx_q              <= '0;
            {fsm_a_q, fsm_b_q} <= mem_q[0];
            state_q            <= StRun;
          end else begin
            rst_cnt_q <= 1'b1;
          end
        end
        StRun: begin
          if (idx_q == last_idx) begin
            {fsm_a_q, fsm_b_q} <= 2'b00;
            state_q            <= StDrain;
          end else begin
            idx_q              <= idx_nxt;
            {fsm_a_q, fsm_b_q} <= mem_q[idx_nxt];
          end
        end
        StDrain: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fsm_rst = fsm_rst_q;
  assign bus.fsm_a   = fsm_a_q;
  assign bus.fsm_b   = fsm_b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;
  assign bus.result  = result_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl; the controlled FSM is modelled as a registered A^B.
module tb_fsm_seq_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fsm_seq_ctrl_if #(.DEPTH(16)) bus ();

  fsm_seq_ctrl #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled FSM model: Out = A^B delayed one cycle.
  always @(posedge clk) bus.fsm_out <= bus.fsm_a ^ bus.fsm_b;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] v);
    bus.wr_en = 1'b1;
    bus.wr_ab = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  logic [1:0] vec10 [10];

  initial begin
    vec10 = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    bus.wr_en = 1'b0;
    bus.wr_ab = 2'b00;
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fsm_rst", 32'(bus.fsm_rst), 32'd1);
    chk("rst_ab", 32'({bus.fsm_a, bus.fsm_b}), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_fsm_rst", 32'(bus.fsm_rst), 32'd0);

    // Start with nothing stored, then clr+start together
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("empty_start_busy", 32'(bus.busy), 32'd0);
    chk("empty_start_err", 32'(bus.err), 32'd1);
    bus.clr   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("clr_start_count", 32'(bus.count), 32'd0);
    chk("clr_start_err", 32'(bus.err), 32'd1);
    chk("clr_start_busy", 32'(bus.busy), 32'd0);

    // Ten-vector playback
    for (int i = 0; i < 10; i++) wr(vec10[i]);
    chk("load10_count", 32'(bus.count), 32'd10);
    bus.start = 1'b1;
    tick();  // start edge T
    bus.start = 1'b0;
    chk("p10_busy", 32'(bus.busy), 32'd1);
    chk("p10_fsm_rst1", 32'(bus.fsm_rst), 32'd1);
    chk("p10_ab_in_rst", 32'({bus.fsm_a, bus.fsm_b}), 32'd0);
    chk("p10_err_cleared", 32'(bus.err), 32'd0);
    tick();  // T+1
    chk("p10_fsm_rst2", 32'(bus.fsm_rst), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();  // T+2+i
      chk("p10_fsm_rst_run", 32'(bus.fsm_rst), 32'd0);
      chk("p10_vec", 32'({bus.fsm_a, bus.fsm_b}), 32'(vec10[i]));
    end
    tick();  // T+12, drain
    chk("p10_drain_ab", 32'({bus.fsm_a, bus.fsm_b}), 32'd0);
    chk("p10_drain_done", 32'(bus.done), 32'd0);
    chk("p10_drain_busy", 32'(bus.busy), 32'd1);
    tick();  // T+13: 14th cycle after start edge
    chk("p10_done", 32'(bus.done), 32'd1);
    tick();
    chk("p10_done_pulse", 32'(bus.done), 32'd0);
    chk("p10_idle_busy", 32'(bus.busy), 32'd0);
    // xor per vector 0,0,0,1,0,0,1,1,0,1 -> 0x2C8, bits 15:10 zero
    chk("p10_result", 32'(bus.result), 32'h0000_02C8);
    chk("p10_count_kept", 32'(bus.count), 32'd10);

    // Replay with wr_en+start injected mid-run
    bus.start = 1'b1;
    tick();  // T
    bus.start = 1'b0;
    tick();  // T+1
    tick();  // T+2, idx0
    bus.wr_en = 1'b1;
    bus.start = 1'b1;
    bus.wr_ab = 2'b11;
    tick();  // T+3
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    chk("busy_wr_vec1", 32'({bus.fsm_a, bus.fsm_b}), 32'(vec10[1]));
    chk("busy_wr_err", 32'(bus.err), 32'd1);
    repeat (9) tick();  // T+12
    chk("busy_wr_drain_done", 32'(bus.done), 32'd0);
    tick();  // T+13
    chk("busy_wr_done", 32'(bus.done), 32'd1);
    chk("busy_wr_result", 32'(bus.result), 32'h0000_02C8);
    chk("busy_wr_count", 32'(bus.count), 32'd10);
    tick();

    // Reset mid-run at idx 5 (err set earlier in the run)
    bus.start = 1'b1;
    tick();  // T
    bus.start = 1'b0;
    repeat (4) tick();  // T+4, idx2
    bus.wr_en = 1'b1;
    tick();  // T+5
    bus.wr_en = 1'b0;
    tick();  // T+6
    tick();  // T+7, idx5
    chk("mid_err_set", 32'(bus.err), 32'd1);
    chk("mid_result_partial", 32'(bus.result), 32'h0000_0008);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_fsm_rst", 32'(bus.fsm_rst), 32'd1);
    chk("mid_rst_ab", 32'({bus.fsm_a, bus.fsm_b}), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rel_fsm_rst", 32'(bus.fsm_rst), 32'd0);

    // Three vectors 01,11,10 -> result 3'b101
    wr(2'b01);
    wr(2'b11);
    wr(2'b10);
    bus.start = 1'b1;
    tick();  // T
    bus.start = 1'b0;
    repeat (5) tick();  // T+5, drain
    chk("p3_drain_done", 32'(bus.done), 32'd0);
    tick();  // T+6
    chk("p3_done", 32'(bus.done), 32'd1);
    chk("p3_result", 32'(bus.result), 32'h0000_0005);
    chk("p3_count", 32'(bus.count), 32'd3);
    tick();

    // Fill all 16, overflow, then a good start clears err
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 16; i++) wr(2'(i));
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_err", 32'(bus.err), 32'd0);
    wr(2'b11);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_err", 32'(bus.err), 32'd1);
    bus.start = 1'b1;
    tick();  // T
    bus.start = 1'b0;
    chk("p16_err_cleared", 32'(bus.err), 32'd0);
    chk("p16_busy", 32'(bus.busy), 32'd1);
    repeat (18) tick();  // T+18, drain
    chk("p16_drain_done", 32'(bus.done), 32'd0);
    tick();  // T+19
    chk("p16_done", 32'(bus.done), 32'd1);
    chk("p16_result", 32'(bus.result), 32'h0000_6666);
    tick();
    chk("p16_idle_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 Parameter: DEPTH, 16, number of stored stimulus vectors (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 wr_en  in  1  append one vector to stimulus memory.
REQ-005 wr_ab  in  2  vector to append; bit1 = A, bit0 = B.
REQ-006 clr  in  1  discard all stored vectors (count to 0).
REQ-007 start  in  1  request playback of stored vectors into the controlled FSM.
REQ-008 fsm_out  in  1  Out of the controlled FSM.
REQ-009 fsm_rst  out  1  active-high reset driven to the controlled FSM.
REQ-010 fsm_a  out  1  A input driven to the controlled FSM.
REQ-011 fsm_b  out  1  B input driven to the controlled FSM.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at playback completion.
REQ-014 count  out  5  number of stored vectors, 0..DEPTH.
REQ-015 result  out  DEPTH  captured fsm_out per vector; bit i belongs to vector i.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 States SHALL be IDLE, DUT_RST, RUN, DRAIN, DONE; all outputs registered.
REQ-018 IDLE, wr_en=1, count<DEPTH: mem[count] <= wr_ab, count += 1 next cycle.
REQ-019 IDLE, wr_en=1, count==DEPTH: write dropped, count unchanged, err <= 1.
REQ-020 IDLE, clr=1: count <= 0, memory contents don't-care; clr has priority over wr_en and start in the same cycle (those are dropped, no err).
REQ-021 IDLE, start=1, wr_en=0, count==0: stay IDLE, err <= 1.
REQ-022 IDLE, start=1, wr_en=0, count>0: err <= 0, result <= 0, idx <= 0, go DUT_RST.
REQ-023 IDLE, start=1 and wr_en=1 same cycle: write dropped, start dropped, err <= 1, stay IDLE.
REQ-024 DUT_RST: fsm_rst = 1 for exactly 2 cycles, then RUN; fsm_rst = 0 in all other states.
REQ-025 RUN: each cycle {fsm_a,fsm_b} = mem[idx]; idx += 1; leave to DRAIN after cycle with idx == count-1.
REQ-026 Capture: fsm_out sampled one cycle after vector i is driven is written to result[i]; result[count-1] captured in DRAIN (1 cycle).
REQ-027 DONE: done = 1 for one cycle, then IDLE; count and memory retained so start replays same vectors.
REQ-028 fsm_a = fsm_b = 0 outside RUN.
REQ-029 wr_en, start or clr while busy: ignored; wr_en or start while busy sets err <= 1.
REQ-030 Playback length: start accepted at edge T -> done high in cycle T+2+count+1+1 (2 DUT_RST, count RUN, 1 DRAIN, DONE).
REQ-031 result bits >= count SHALL remain 0.

Reset
REQ-032 rst=0 sampled at a rising edge from any state (including mid-RUN): state IDLE, count 0, idx 0, result 0, err 0, done 0, busy 0, fsm_a 0, fsm_b 0, fsm_rst 1 (FSM held in reset while rst low); fsm_rst 0 first cycle after rst returns 1.

Verification
REQ-033 Load 10 vectors 00,11,11,10,00,00,01,10,11,01, start -> count=10, busy 1, fsm_rst high 2 cycles, vectors in order on fsm_a/fsm_b, done 14 cycles after start edge, result[15:10]=0.
REQ-034 Load 16 vectors, one more wr_en -> count stays 16, err=1; next valid start clears err.
REQ-035 start with count=0 -> no busy, err=1; clr with start same cycle -> count=0, err unchanged.
REQ-036 Tie fsm_out = fsm_a^fsm_b delayed 1 cycle, load 01,11,10 -> result[2:0]=3'b101.
REQ-037 rst low during RUN at idx=5 -> next cycle all outputs per REQ-032; new load/start completes normally.
REQ-038 wr_en and start during RUN -> ignored, err=1, playback and result unaffected.
